// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - I2C write-only codec control-port responder with 16 x 9-bit register file
// Optional majority glitch filter on SCL/SDA: define I2C_RESP_GLITCH_FILTER_EN.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         N_REGS    = 16,
   parameter logic [6:0] RESET_REG = 7'h0F
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   input  logic [3:0] i_reg_sel,
   output logic [8:0] o_reg_data,
   output logic       o_wr_valid,
   output logic [6:0] o_wr_addr,
   output logic [8:0] o_wr_data,
   output logic       o_err,
   output logic       o_busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ADDR      = 3'd1;
   localparam logic [2:0] S_ACK_A     = 3'd2;
   localparam logic [2:0] S_BYTE1     = 3'd3;
   localparam logic [2:0] S_ACK_1     = 3'd4;
   localparam logic [2:0] S_BYTE2     = 3'd5;
   localparam logic [2:0] S_ACK_2     = 3'd6;
   localparam logic [2:0] S_WAIT_STOP = 3'd7;

   logic scl_s1, scl_s2, scl_h, scl_v;
   logic sda_s1, sda_s2, sda_h, sda_v;
   logic scl_rise, scl_fall, start_c, stop_c;

   logic [2:0] state;
   logic [7:0] shreg;
   logic [3:0] bitcnt;
   logic [6:0] reg_addr;
   logic       d8;
   logic       shifting, byte_done, in_range, is_reset_reg;
   logic [8:0] regs [N_REGS];

   // Synchronisers idle high so a reset never fabricates a bus condition.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= i_scl;
         scl_s2 <= scl_s1;
         sda_s1 <= i_sda;
         sda_s2 <= sda_s1;
      end
   end

`ifdef I2C_RESP_GLITCH_FILTER_EN
   logic [1:0] scl_d, sda_d;
   logic       scl_f, sda_f;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_d <= 2'b11;
         sda_d <= 2'b11;
         scl_f <= 1'b1;
         sda_f <= 1'b1;
      end else begin
         scl_d <= {scl_d[0], scl_s2};
         sda_d <= {sda_d[0], sda_s2};
         scl_f <= (scl_s2 & scl_d[0]) | (scl_s2 & scl_d[1]) | (scl_d[0] & scl_d[1]);
         sda_f <= (sda_s2 & sda_d[0]) | (sda_s2 & sda_d[1]) | (sda_d[0] & sda_d[1]);
      end
   end

   assign scl_v = scl_f;
   assign sda_v = sda_f;
`else
   assign scl_v = scl_s2;
   assign sda_v = sda_s2;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_h <= 1'b1;
         sda_h <= 1'b1;
      end else begin
         scl_h <= scl_v;
         sda_h <= sda_v;
      end
   end

   assign scl_rise = scl_v & ~scl_h;
   assign scl_fall = ~scl_v & scl_h;
   assign start_c  = scl_v & scl_h & sda_h & ~sda_v;
   assign stop_c   = scl_v & scl_h & ~sda_h & sda_v;

   assign shifting     = (state == S_ADDR) || (state == S_BYTE1) || (state == S_BYTE2);
   assign byte_done    = (bitcnt == 4'd8);
   assign in_range     = (32'(reg_addr) < N_REGS);
   assign is_reset_reg = (reg_addr == RESET_REG);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         reg_addr   <= '0;
         d8         <= 1'b0;
         o_sda_oe   <= 1'b0;
         o_wr_valid <= 1'b0;
         o_err      <= 1'b0;
         o_busy     <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      end else begin
         o_wr_valid <= 1'b0;
         o_err      <= 1'b0;
         if (start_c) begin
            state    <= S_ADDR;
            bitcnt   <= '0;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b1;
         end else if (stop_c) begin
            state    <= S_IDLE;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
         end else begin
            if (scl_rise && shifting && !byte_done) begin
               shreg  <= {shreg[6:0], sda_v};
               bitcnt <= bitcnt + 4'd1;
            end
            if (scl_fall) begin
               case (state)
                  S_ADDR: if (byte_done) begin
                     if (shreg == {DEV_ADDR, 1'b0}) begin
                        o_sda_oe <= 1'b1;
                        state    <= S_ACK_A;
                     end else begin
                        o_err <= (shreg[7:1] == DEV_ADDR);
                        state <= S_WAIT_STOP;
                     end
                  end
                  S_BYTE1: if (byte_done) begin
                     reg_addr <= shreg[7:1];
                     d8       <= shreg[0];
                     o_sda_oe <= 1'b1;
                     state    <= S_ACK_1;
                  end
                  S_BYTE2: if (byte_done) begin
                     o_sda_oe <= 1'b1;
                     state    <= S_ACK_2;
                     if (in_range || is_reset_reg) begin
                        o_wr_valid <= 1'b1;
                        o_wr_addr  <= reg_addr;
                        o_wr_data  <= {d8, shreg};
                        for (int i = 0; i < N_REGS; i++)
                           if (32'(reg_addr) == i) regs[i] <= {d8, shreg};
                        // Later assignment: the reset-register clear overrides the store.
                        if (is_reset_reg)
                           for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
                     end else begin
                        o_err <= 1'b1;
                     end
                  end
                  S_ACK_A: begin
                     o_sda_oe <= 1'b0;
                     bitcnt   <= '0;
                     state    <= S_BYTE1;
                  end
                  S_ACK_1: begin
                     o_sda_oe <= 1'b0;
                     bitcnt   <= '0;
                     state    <= S_BYTE2;
                  end
                  S_ACK_2: begin
                     o_sda_oe <= 1'b0;
                     bitcnt   <= '0;
                     state    <= S_WAIT_STOP;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      o_reg_data = '0;
      for (int i = 0; i < N_REGS; i++)
         if (32'(i_reg_sel) == i) o_reg_data = regs[i];
   end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - randomized bus-level bench for i2c_codec_responder
module tb_i2c_codec_responder;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl;
   logic       m_sda;
   logic       sda_bus;
   logic       sda_oe;
   logic [3:0] reg_sel;
   logic [8:0] reg_data;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       err;
   logic       busy;

   always #5 clk = ~clk;

   assign sda_bus = m_sda & ~sda_oe;

   i2c_codec_responder dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_scl      (scl),
      .i_sda      (sda_bus),
      .o_sda_oe   (sda_oe),
      .i_reg_sel  (reg_sel),
      .o_reg_data (reg_data),
      .o_wr_valid (wr_valid),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_err      (err),
      .o_busy     (busy)
   );

   int errors = 0;
   int checks = 0;

   int wv_cycles = 0;
   int err_cycles = 0;
   int oe_cycles = 0;

   logic [8:0] ref_regs [16];
   logic [6:0] exp_wa;
   logic [8:0] exp_wd;

   always @(negedge clk) begin
      if (wr_valid === 1'b1) wv_cycles++;
      if (err === 1'b1) err_cycles++;
      if (sda_oe === 1'b1) oe_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input logic do_ack, output logic ack);
      ack = 1'b0;
      for (int i = 7; i > 7 - n; i--) begin
         wait_clks(Q); m_sda = b[i];
         wait_clks(Q); scl = 1'b1;
         wait_clks(2 * Q); scl = 1'b0;
      end
      if (do_ack) begin
         wait_clks(Q); m_sda = 1'b1;
         wait_clks(Q); scl = 1'b1;
         wait_clks(Q); ack = ~sda_bus;
         wait_clks(Q); scl = 1'b0;
      end
   endtask

   task automatic start_cond();
      if (scl) begin
         m_sda = 1'b0;
         wait_clks(2 * Q); scl = 1'b0;
      end else begin
         wait_clks(Q); m_sda = 1'b1;
         wait_clks(Q); scl = 1'b1;
         wait_clks(Q); m_sda = 1'b0;
         wait_clks(Q); scl = 1'b0;
      end
   endtask

   task automatic stop_cond();
      wait_clks(Q); m_sda = 1'b0;
      wait_clks(Q); scl = 1'b1;
      wait_clks(Q); m_sda = 1'b1;
      wait_clks(2 * Q);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) begin
         reg_sel = 4'(i);
         #1;
         check($sformatf("%s_reg%0d", tag, i), 32'(reg_data), 32'(ref_regs[i]));
      end
   endtask

   // kind: 0 full write, 1 STOP mid byte2, 2 repeated START after byte1, 3 full write plus extra byte
   task automatic do_txn(input int kind, input logic [7:0] ab, input logic [6:0] ra, input logic [8:0] dat);
      int   wv0, er0, oe0, exp_wv, exp_er;
      logic ack, addr_ok;
      wv0 = wv_cycles; er0 = err_cycles; oe0 = oe_cycles;
      exp_wv = 0;
      exp_er = (ab == 8'h35) ? 1 : 0;
      addr_ok = (ab == 8'h34);
      start_cond();
      check("busy_start", 32'(busy), 32'd1);
      send_bits(ab, 8, 1'b1, ack);
      check("ack_addr", 32'(ack), 32'(addr_ok));
      send_bits({ra, dat[8]}, 8, 1'b1, ack);
      check("ack_byte1", 32'(ack), 32'(addr_ok));
      if (kind == 1) begin
         send_bits(dat[7:0], 4, 1'b0, ack);
         stop_cond();
      end else if (kind != 2) begin
         send_bits(dat[7:0], 8, 1'b1, ack);
         check("ack_byte2", 32'(ack), 32'(addr_ok));
         if (addr_ok) begin
            if (ra < 7'd16 || ra == 7'h0F) begin
               exp_wv = 1;
               exp_wa = ra;
               exp_wd = dat;
               if (ra < 7'd16) ref_regs[ra[3:0]] = dat;
               if (ra == 7'h0F) clear_model();
            end else begin
               exp_er = 1;
            end
         end
         if (kind == 3) begin
            send_bits(8'($urandom), 8, 1'b1, ack);
            check("ack_extra", 32'(ack), 32'd0);
         end
         stop_cond();
      end
      wait_clks(2);
      if (kind != 2) check("busy_stop", 32'(busy), 32'd0);
      check("wr_valid_cycles", 32'(wv_cycles - wv0), 32'(exp_wv));
      check("err_cycles", 32'(err_cycles - er0), 32'(exp_er));
      if (!addr_ok) check("oe_quiet", 32'(oe_cycles - oe0), 32'd0);
      check("wr_addr", 32'(wr_addr), 32'(exp_wa));
      check("wr_data", 32'(wr_data), 32'(exp_wd));
      check_regs("regs");
   endtask

   initial begin
      logic       ack;
      int         r, kind;
      logic [7:0] ab;
      logic [6:0] ra;

      rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1; reg_sel = '0;
      clear_model();
      exp_wa = '0; exp_wd = '0;
      wait_clks(4);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      rst_n = 1'b1;
      wait_clks(4);
      check_regs("rst");

      do_txn(0, 8'h34, 7'd6, 9'h05A);
      do_txn(0, 8'h36, 7'd6, 9'h1FF);
      do_txn(0, 8'h34, 7'd2, 9'h123);
      do_txn(0, 8'h34, 7'h0F, 9'h000);
      do_txn(1, 8'h34, 7'd5, 9'h0AA);
      do_txn(0, 8'h34, 7'd3, 9'h1FF);
      do_txn(2, 8'h34, 7'd7, 9'h111);
      do_txn(0, 8'h34, 7'd4, 9'h080);
      do_txn(0, 8'h35, 7'd8, 9'h0C3);
      do_txn(0, 8'h34, 7'h40, 9'h155);
      do_txn(3, 8'h34, 7'd1, 9'h101);

      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 9));
         ab = (r < 6) ? 8'h34 : (r == 6) ? 8'h35 : (r == 7) ? 8'h36 : 8'($urandom);
         ra = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 15)) : 7'($urandom);
         r = int'($urandom_range(0, 7));
         kind = (r < 4) ? 0 : r - 3;
         if (kind > 3) kind = 0;
         do_txn(kind, ab, ra, 9'($urandom));
      end

      do_txn(0, 8'h34, 7'd9, 9'h0F0);
      start_cond();
      send_bits(8'h34, 8, 1'b1, ack);
      check("rst_mid_ack_addr", 32'(ack), 32'd1);
      send_bits(8'h0C, 8, 1'b0, ack);
      wait_clks(Q);
      check("oe_before_rst", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      wait_clks(1);
      clear_model();
      exp_wa = '0; exp_wd = '0;
      check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
      check_regs("rst_mid");
      m_sda = 1'b1;
      scl = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(5);
      do_txn(0, 8'h34, 7'd11, 9'h1A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
